// File: rtl/fp_normalizer_pkg.sv
// fp_normalizer_pkg: shared widths, hidden-bit position and flag layout
package fp_normalizer_pkg;
    localparam int WORD_SIZE_D = 25;
    localparam int EXP_W_D = 8;
    localparam int IDX_W = 8;
    localparam int HIDDEN_BIT = WORD_SIZE_D - 2;
    typedef enum logic {SH_LEFT = 1'b0, SH_RIGHT = 1'b1} shift_dir_t;
    typedef struct packed {
        logic zero;
        logic inexact;
        logic overflow;
        logic underflow;
        logic idx_err;
    } norm_flags_t;
endpackage

// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: valid/ready input beat and result bus of the normalizer
interface fp_normalizer_if import fp_normalizer_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_D,
    parameter int EXP_W = EXP_W_D
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_mantissa;
    logic [EXP_W-1:0]     in_exponent;
    logic [IDX_W-1:0]     in_msb_index;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_mantissa;
    logic [EXP_W-1:0]     out_exponent;
    logic                 out_zero;
    logic                 out_inexact;
    logic                 out_overflow;
    logic                 out_underflow;
    logic                 out_idx_err;
    modport master (
        output in_valid, in_mantissa, in_exponent, in_msb_index, out_ready,
        input  in_ready, out_valid, out_mantissa, out_exponent,
               out_zero, out_inexact, out_overflow, out_underflow, out_idx_err
    );
    modport slave (
        input  in_valid, in_mantissa, in_exponent, in_msb_index, out_ready,
        output in_ready, out_valid, out_mantissa, out_exponent,
               out_zero, out_inexact, out_overflow, out_underflow, out_idx_err
    );
endinterface

// File: rtl/fp_normalizer_norm_shifter.sv
// norm_shifter: combinational log-stage left/right barrel shifter
module norm_shifter import fp_normalizer_pkg::*; #(
    parameter int W = WORD_SIZE_D,
    parameter int SH_W = $clog2(WORD_SIZE_D)
) (
    input  logic [W-1:0]    data,
    input  logic [SH_W-1:0] amount,
    input  shift_dir_t      dir,
    output logic [W-1:0]    result
);
    logic [W-1:0] stage [SH_W+1];
    assign stage[0] = data;
    for (genvar i = 0; i < SH_W; i++) begin : g_stage
        assign stage[i+1] = amount[i] ? (dir == SH_RIGHT ? stage[i] >> (1 << i) : stage[i] << (1 << i)) : stage[i];
    end
    assign result = stage[SH_W];
endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: 2-stage pipeline moving the leading one to the hidden-bit position
module fp_normalizer import fp_normalizer_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_D,
    parameter int EXP_W = EXP_W_D
) (
    input logic          clk,
    input logic          rst,
    fp_normalizer_if.slave bus
);
    localparam int T = WORD_SIZE - 2;
    localparam int SH_W = $clog2(WORD_SIZE);

    logic                 s1_valid, s1_advance, s2_advance, in_rdy;
    logic [WORD_SIZE-1:0] s1_mant;
    logic [EXP_W-1:0]     s1_exp;
    shift_dir_t           s1_dir;
    logic [SH_W-1:0]      s1_amt;
    logic                 s1_zero, s1_err;
    logic [WORD_SIZE-1:0] in_hi;
    logic                 in_zero, in_err;
    shift_dir_t           in_dir;
    logic [SH_W-1:0]      in_amt;
    logic                 out_valid_r;
    logic [WORD_SIZE-1:0] out_mant_r, nx_mant, sh_out;
    logic [EXP_W-1:0]     out_exp_r, nx_exp;
    norm_flags_t          out_flags_r, nx_flags;
    logic [EXP_W:0]       exp_inc;
    logic                 ovf, ufl;

    assign s2_advance = !out_valid_r || bus.out_ready;
    assign s1_advance = s1_valid && s2_advance;
    assign in_rdy = !s1_valid || s1_advance;

    // Consistency holds when shifting the mantissa down by idx leaves exactly 1.
    always_comb begin
        in_hi = bus.in_mantissa >> bus.in_msb_index;
        in_zero = bus.in_mantissa == '0;
        in_err = !in_zero && (bus.in_msb_index >= IDX_W'(WORD_SIZE) || in_hi != WORD_SIZE'(1));
        in_dir = bus.in_msb_index == IDX_W'(WORD_SIZE - 1) ? SH_RIGHT : SH_LEFT;
        in_amt = in_dir == SH_RIGHT ? SH_W'(1) : SH_W'(T) - bus.in_msb_index[SH_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant <= '0;
            s1_exp <= '0;
            s1_dir <= SH_LEFT;
            s1_amt <= '0;
            s1_zero <= 1'b0;
            s1_err <= 1'b0;
        end else if (in_rdy) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mant <= bus.in_mantissa;
                s1_exp <= bus.in_exponent;
                s1_dir <= in_dir;
                s1_amt <= in_amt;
                s1_zero <= in_zero;
                s1_err <= in_err;
            end
        end
    end

    norm_shifter #(.W(WORD_SIZE), .SH_W(SH_W)) u_shifter (
        .data  (s1_mant),
        .amount(s1_amt),
        .dir   (s1_dir),
        .result(sh_out)
    );

    always_comb begin
        exp_inc = {1'b0, s1_exp} + (EXP_W+1)'(1);
        ovf = exp_inc >= {1'b0, {EXP_W{1'b1}}};
        ufl = s1_exp <= EXP_W'(s1_amt);
        nx_flags = '0;
        nx_mant = sh_out;
        nx_exp = s1_exp - EXP_W'(s1_amt);
        if (s1_zero) begin
            nx_mant = '0;
            nx_exp = '0;
            nx_flags.zero = 1'b1;
        end else if (s1_err) begin
            nx_mant = s1_mant;
            nx_exp = s1_exp;
            nx_flags.idx_err = 1'b1;
        end else if (s1_dir == SH_RIGHT) begin
            nx_flags.inexact = s1_mant[0];
            nx_flags.overflow = ovf;
            nx_mant = ovf ? '0 : sh_out;
            nx_exp = ovf ? '1 : exp_inc[EXP_W-1:0];
        end else if (ufl) begin
            nx_mant = '0;
            nx_exp = '0;
            nx_flags.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_mant_r <= '0;
            out_exp_r <= '0;
            out_flags_r <= '0;
        end else if (s2_advance) begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                out_mant_r <= nx_mant;
                out_exp_r <= nx_exp;
                out_flags_r <= nx_flags;
            end
        end
    end

    assign bus.in_ready = in_rdy;
    assign bus.out_valid = out_valid_r;
    assign bus.out_mantissa = out_mant_r;
    assign bus.out_exponent = out_exp_r;
    assign bus.out_zero = out_flags_r.zero;
    assign bus.out_inexact = out_flags_r.inexact;
    assign bus.out_overflow = out_flags_r.overflow;
    assign bus.out_underflow = out_flags_r.underflow;
    assign bus.out_idx_err = out_flags_r.idx_err;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: scoreboard bench for fp_normalizer
module tb_fp_normalizer;
    logic clk, rst;
    int checks = 0;
    int errors = 0;
    int nbeat = 0;
    logic [37:0] exp_q [$];
    logic [37:0] out_vec, hold_vec;
    logic rnd_busy;

    fp_normalizer_if bus ();
    fp_normalizer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign out_vec = {bus.out_mantissa, bus.out_exponent, bus.out_zero, bus.out_inexact,
                      bus.out_overflow, bus.out_underflow, bus.out_idx_err};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Flag order: zero, inexact, overflow, underflow, idx_err
    function automatic logic [37:0] model(input logic [24:0] m, input logic [7:0] e, input logic [7:0] idx);
        int msb;
        int sh;
        msb = -1;
        for (int i = 0; i < 25; i++) if (m[i]) msb = i;
        if (m == 25'd0) return {25'd0, 8'd0, 5'b10000};
        if (int'(idx) != msb) return {m, e, 5'b00001};
        if (msb == 24) begin
            if (int'(e) + 1 >= 255) return {25'd0, 8'hFF, 1'b0, m[0], 1'b1, 2'b00};
            return {m >> 1, e + 8'd1, 1'b0, m[0], 3'b000};
        end
        sh = 23 - msb;
        if (int'(e) <= sh) return {25'd0, 8'd0, 5'b00010};
        return {m << sh, e - 8'(sh), 5'b00000};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("queue_nonempty_at_beat", 64'(exp_q.size()), 64'd1);
            else chk($sformatf("beat%0d", nbeat), 64'(out_vec), 64'(exp_q.pop_front()));
            nbeat++;
        end
    end

    task automatic drive(input logic [24:0] m, input logic [7:0] e, input logic [7:0] idx);
        bus.in_valid = 1'b1;
        bus.in_mantissa = m;
        bus.in_exponent = e;
        bus.in_msb_index = idx;
        exp_q.push_back(model(m, e, idx));
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [24:0] m, input logic [7:0] e, input logic [7:0] idx);
        drive(m, e, idx);
        wait_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    logic [24:0] tm [14] = '{25'h0800000, 25'h1000001, 25'h0000010, 25'h0000001, 25'h1000000, 25'h0000000,
                             25'h0000010, 25'h0800000, 25'h0C00000, 25'h0000010, 25'h0000010, 25'h1000000,
                             25'h1FFFFFF, 25'h0400003};
    logic [7:0] te [14] = '{8'h80, 8'h7F, 8'h90, 8'h05, 8'hFE, 8'h33, 8'h44, 8'h12, 8'h20, 8'd19, 8'd20, 8'hFD,
                            8'h10, 8'h02};
    logic [7:0] ti [14] = '{8'd23, 8'd24, 8'd4, 8'd0, 8'd24, 8'd9, 8'd7, 8'd30, 8'd22, 8'd4, 8'd4, 8'd24,
                            8'd24, 8'd22};

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mantissa = '0;
        bus.in_exponent = '0;
        bus.in_msb_index = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(out_vec), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(25'h0800000, 8'h80, 8'd23);
        @(negedge clk);
        chk("lat_cycle1_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        for (int k = 0; k < 14; k++) send(tm[k], te[k], ti[k]);
        drain();

        rnd_busy = 1'b1;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    logic [31:0] r;
                    int idx;
                    idx = $urandom_range(0, 24);
                    r = $urandom;
                    if ((k % 8) == 7) send(25'd0, 8'($urandom), 8'(idx));
                    else send(25'((32'd1 << idx) | (r & ((32'd1 << idx) - 1))), 8'($urandom), 8'(idx));
                end
                rnd_busy = 1'b0;
            end
            begin
                for (int i = 0; i < 2000 && rnd_busy; i++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        bus.out_ready = 1'b0;
        drive(25'h0000020, 8'h40, 8'd5);
        @(posedge clk);
        #1;
        drive(25'h1000003, 8'h10, 8'd24);
        @(posedge clk);
        #1;
        drive(25'h0000000, 8'h01, 8'd0);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        hold_vec = out_vec;
        @(negedge clk);
        chk("bp_hold1", 64'(out_vec), 64'(hold_vec));
        chk("bp_in_ready_still_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("bp_hold2", 64'(out_vec), 64'(hold_vec));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept();
        send(25'h0000400, 8'h0B, 8'd10);
        drain();

        bus.out_ready = 1'b0;
        send(25'h0800000, 8'h55, 8'd23);
        send(25'h0400000, 8'h66, 8'd22);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
